// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the unified-memory port arbiter.
// Contents: response-owner FSM encoding, grant-owner encoding, memory
//           read/write mode constants and default widths.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF     = 10;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned BE_W           = 4;
   localparam int unsigned CNT_W          = 4;
   localparam int unsigned STARVE_MAX_DEF = 4;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_LS} rsp_state_t;
   typedef enum logic {GNT_IF, GNT_LS} gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, load/store and memory-macro signals of the
//          arbiter into one interface.
// Modports:
//   slave  - arbiter view: requests/addresses/store data/mem_read_data in,
//            grants, rvalids, rdata and mem_* drive out.
//   master - environment view (requesters + memory macro), directions mirrored.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   // fetch path
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // load/store path
   logic              ls_req;
   logic              ls_rw;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [BE_W-1:0]   ls_be;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   // memory macro port
   logic              mem_en;
   logic              mem_rw_mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic [BE_W-1:0]   mem_byte_en;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata, ls_be, mem_read_data,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en
   );

   modport master (
      output if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata, ls_be, mem_read_data,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Purpose: combinational grant selector, at most one grant per cycle.
// Ports:
//   if_req, ls_req      - (reset-masked) requests
//   starve_cnt          - consecutive ls wins while fetch waits (fixed priority)
//   last_gnt            - owner of the previous grant (MEM_ARB_RR_EN build)
//   if_gnt, ls_gnt      - one-hot-or-zero grants
// Build option: MEM_ARB_RR_EN selects strict alternation on conflict instead of
//               ls priority with the starvation override.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic             if_req,
   input  logic             ls_req,
`ifdef MEM_ARB_RR_EN
   input  gnt_t             last_gnt,
`else
   input  logic [CNT_W-1:0] starve_cnt,
`endif
   output logic             if_gnt,
   output logic             ls_gnt
);

   // A sole requester always wins; only the conflict case needs a policy.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
         if (last_gnt == GNT_IF) ls_gnt = 1'b1;
         else                    if_gnt = 1'b1;
`else
         if (starve_cnt == CNT_W'(STARVE_MAX)) if_gnt = 1'b1;
         else                                  ls_gnt = 1'b1;
`endif
      end else begin
         if_gnt = if_req;
         ls_gnt = ls_req;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single-ported unified memory between instruction fetch
//          and IEU load/store, drives the memory port and steers the
//          1-cycle-latency read data back to the owner of the read.
// Ports:
//   i_clk - clock, all state on rising edge
//   i_rst - asynchronous active-high reset
//   bus   - mem_port_arbiter_if.slave: fetch req/gnt/rdata, load/store
//           req/gnt/rdata, memory macro drive and read data
// Build option: MEM_ARB_RR_EN - strict alternation on conflict (tracks
//               last_gnt); undefined - ls priority with STARVE_MAX override.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   mem_port_arbiter_if.slave   bus
);

   logic       if_req_m;
   logic       ls_req_m;
   logic       if_gnt;
   logic       ls_gnt;
   rsp_state_t rsp_state;
   rsp_state_t rsp_state_nxt;

   // Grants are masked while reset is asserted so the memory port stays idle.
   assign if_req_m = bus.if_req & ~i_rst;
   assign ls_req_m = bus.ls_req & ~i_rst;

`ifdef MEM_ARB_RR_EN
   gnt_t last_gnt;

   // Owner of the most recent grant; reset value makes ls win the first conflict.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       last_gnt <= GNT_IF;
      else if (if_gnt) last_gnt <= GNT_IF;
      else if (ls_gnt) last_gnt <= GNT_LS;
   end

   mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .if_req   (if_req_m),
      .ls_req   (ls_req_m),
      .last_gnt (last_gnt),
      .if_gnt   (if_gnt),
      .ls_gnt   (ls_gnt)
   );
`else
   logic [CNT_W-1:0] starve_cnt;

   // Counts ls wins over a waiting fetch; saturates so the override sticks.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         starve_cnt <= '0;
      else if (if_gnt || !bus.if_req)
         starve_cnt <= '0;
      else if (ls_gnt && (starve_cnt < CNT_W'(STARVE_MAX)))
         starve_cnt <= starve_cnt + CNT_W'(1);
   end

   mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .if_req     (if_req_m),
      .ls_req     (ls_req_m),
      .starve_cnt (starve_cnt),
      .if_gnt     (if_gnt),
      .ls_gnt     (ls_gnt)
   );
`endif

   assign bus.if_gnt = if_gnt;
   assign bus.ls_gnt = ls_gnt;

   // Memory drive; every field is zero when not used so the port can be OR-combined.
   always_comb begin
      bus.mem_en         = 1'b0;
      bus.mem_rw_mode    = MEM_RD;
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      bus.mem_byte_en    = '0;
      if (ls_gnt) begin
         bus.mem_en      = 1'b1;
         bus.mem_rw_mode = bus.ls_rw;
         bus.mem_addr    = bus.ls_addr;
         if (bus.ls_rw == MEM_WR) begin
            bus.mem_write_data = bus.ls_wdata;
            bus.mem_byte_en    = bus.ls_be;
         end
      end else if (if_gnt) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.if_addr;
      end
   end

   // Response owner register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rsp_state <= RSP_NONE;
      else       rsp_state <= rsp_state_nxt;
   end

   // Next owner: only reads produce a response; writes leave the port free.
   always_comb begin
      rsp_state_nxt = RSP_NONE;
      if (if_gnt)                               rsp_state_nxt = RSP_IF;
      else if (ls_gnt && (bus.ls_rw == MEM_RD)) rsp_state_nxt = RSP_LS;
   end

   // Steer read data to its owner; the other side sees zero.
   always_comb begin
      bus.if_rvalid = 1'b0;
      bus.ls_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.ls_rdata  = '0;
      case (rsp_state)
         RSP_IF: begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_read_data;
         end
         RSP_LS: begin
            bus.ls_rvalid = 1'b1;
            bus.ls_rdata  = bus.mem_read_data;
         end
         default: ;
      endcase
   end

endmodule
